dict_value_decompressor: RTL and testbench
==========================================

# dict_value_decompressor

Downstream stage of the dictionary-value compressor path. Takes the packed vector of NUM_CHUNKS codebook indices produced after compression completes and expands each index back into its CHUNK_SIZE-bit representative codeword. It emits the reconstructed stream one bit per accepted transfer, MSB-first, over a valid/ready handshake. It is the reference decoder used for round-trip checks of the compressor and for feeding the reconstructed unary bitstream to downstream consumers.

## Interface
- CHUNK_SIZE, 4, bits per reconstructed chunk; the codebook is defined only for 4.
- CODEBOOK_SIZE, 8, number of codebook entries.
- INDEX_BITS, $clog2(CODEBOOK_SIZE), width of one index.
- NUM_CHUNKS, 32, number of indices in one packed frame.
- clk  input  1  clock, rising-edge.
- rst_n  input  1  reset, asynchronous, active-low.
- compressed_in  input  NUM_CHUNKS*INDEX_BITS  packed indices; chunk i occupies [(i+1)*INDEX_BITS-1 : i*INDEX_BITS].
- start  input  1  frame start; sampled only in IDLE.
- busy  output  1  high while a frame is being emitted.
- data_out  output  1  reconstructed bit.
- data_valid_out  output  1  data_out is valid.
- data_ready  input  1  consumer accepts data_out at this edge when data_valid_out is also high.
- done  output  1  one-cycle pulse after the final bit of a frame is accepted.

## Operation
- Codebook (index -> codeword, bit3..bit0): 0->0000, 1->0001, 2->0011, 3->1110, 4->1111, 5->1000, 6->1100, 7->0111. Every codeword re-compresses to its own index.
- States: IDLE, EMIT.
- IDLE: busy=0, data_valid_out=0. When start=1 at an edge:
  - capture compressed_in into an internal frame register;
  - load codeword(chunk 0) into the output shift register;
  - clear chunk_cnt and bit_cnt;
  - go to EMIT.
- compressed_in may change freely after the capture edge.
- EMIT: busy=1, data_valid_out=1, data_out = MSB of the output shift register.
- Accept = data_valid_out & data_ready at a rising edge. On accept:
  - If bit_cnt < CHUNK_SIZE-1: shift left, bit_cnt+1.
  - Else, if chunk_cnt < NUM_CHUNKS-1: bit_cnt=0, chunk_cnt+1, load codeword(chunk_cnt+1).
  - Else (final bit of the frame): pulse done, return to IDLE.
- No accept: data_out, data_valid_out and all counters hold.
- Chunk order: chunk 0 first. Bit order within a chunk: bit3 first, matching the compressor's MSB-first shift-in.
- start while in EMIT is ignored. No queuing.
- Counter widths: chunk_cnt $clog2(NUM_CHUNKS), bit_cnt $clog2(CHUNK_SIZE). Neither wraps inside a frame.
- Out-of-range index: does not occur for CODEBOOK_SIZE=8. The lookup default is 0000.

## Timing
- Reset values: busy=0, data_valid_out=0, data_out=0, done=0. State=IDLE, counters=0, frame and shift registers=0.
- All outputs are registered.
- Latency: start sampled at edge N -> data_valid_out=1 with bit3 of chunk 0 in the cycle after edge N.
- Throughput: 1 bit/cycle with data_ready held high. A frame takes NUM_CHUNKS*CHUNK_SIZE = 128 cycles.
- Chunk boundaries add no bubble.
- done is high for exactly the cycle after the final accept edge. In that cycle busy=0 and data_valid_out=0.
- start=1 in the done cycle is accepted, giving back-to-back frames with a one-cycle gap.
- rst_n asserted mid-frame: all state returns to reset values immediately. No done pulse. The partial frame is discarded. The next start begins a fresh frame at chunk 0.
- data_ready low on the final bit: done waits for the accept.

## Test plan
- Reset: assert rst_n=0 mid-EMIT at chunk 10 -> outputs go to 0 immediately, and no done. A new start emits chunk 0 in the next cycle.
- All-zero frame: compressed_in=0, start pulse, data_ready=1 -> 128 cycles of data_out=0, done in cycle 129 after start, busy falls with done.
- Codebook sweep: indices 0,1,...,7 repeated four times, data_ready=1 -> bit sequence 0000 0001 0011 1110 1111 1000 1100 0111, repeated four times, no bubbles.
- Backpressure: data_ready toggles 1,0,0,1,... randomly -> each bit is held stable until accepted, the sequence is identical to the no-stall run, and done follows the final accept.
- Ignored start plus back-to-back frames: pulse start at cycle 50 of frame A with a new compressed_in -> frame A is unaffected. Pulse start in the done cycle -> frame B starts in the next cycle with B's chunk 0.
- Round-trip: random 128-bit stream -> compressor -> this block -> compressor again. The second set of indices must match the first for all 32 chunks.

Source files
------------

// File: rtl/dict_value_decompressor.sv
// rtl/dict_value_decompressor.sv - expands packed codebook indices into an MSB-first bitstream
// One bit per accepted valid/ready transfer; chunk 0 first, codeword bit3 first.
module dict_value_decompressor #(
  parameter int CHUNK_SIZE    = 4,
  parameter int CODEBOOK_SIZE = 8,
  parameter int INDEX_BITS    = $clog2(CODEBOOK_SIZE),
  parameter int NUM_CHUNKS    = 32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_CHUNKS*INDEX_BITS-1:0] compressed_in,
  input  logic                             start,
  output logic                             busy,
  output logic                             data_out,
  output logic                             data_valid_out,
  input  logic                             data_ready,
  output logic                             done
);

  localparam int FRAME_W = NUM_CHUNKS * INDEX_BITS;
  localparam int CNT_W   = $clog2(NUM_CHUNKS);
  localparam int BIT_W   = $clog2(CHUNK_SIZE);
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NUM_CHUNKS - 1);
  localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(CHUNK_SIZE - 1);

  typedef enum logic {IDLE, EMIT} state_e;

  state_e                  state_q, state_d;
  logic [FRAME_W-1:0]      frame_q, frame_d;
  logic [CHUNK_SIZE-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]        chunk_cnt_q, chunk_cnt_d;
  logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic                    done_q, done_d;
  logic [CNT_W-1:0]        next_chunk;
  logic [INDEX_BITS-1:0]   next_idx;

  function automatic logic [CHUNK_SIZE-1:0] codeword(input logic [INDEX_BITS-1:0] idx);
    logic [3:0] cw4;
    case (int'(idx))
      0:       cw4 = 4'b0000;
      1:       cw4 = 4'b0001;
      2:       cw4 = 4'b0011;
      3:       cw4 = 4'b1110;
      4:       cw4 = 4'b1111;
      5:       cw4 = 4'b1000;
      6:       cw4 = 4'b1100;
      7:       cw4 = 4'b0111;
      default: cw4 = 4'b0000;
    endcase
    return CHUNK_SIZE'(cw4);
  endfunction

  assign next_chunk = chunk_cnt_q + 1'b1;
  assign next_idx   = frame_q[next_chunk*INDEX_BITS +: INDEX_BITS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      frame_q     <= '0;
      shift_q     <= '0;
      chunk_cnt_q <= '0;
      bit_cnt_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_q     <= frame_d;
      shift_q     <= shift_d;
      chunk_cnt_q <= chunk_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    frame_d     = frame_q;
    shift_d     = shift_q;
    chunk_cnt_d = chunk_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          frame_d     = compressed_in;
          shift_d     = codeword(compressed_in[INDEX_BITS-1:0]);
          chunk_cnt_d = '0;
          bit_cnt_d   = '0;
          state_d     = EMIT;
        end
      end
      EMIT: begin
        if (data_ready) begin
          if (bit_cnt_q != LAST_BIT) begin
            shift_d   = shift_q << 1;
            bit_cnt_d = bit_cnt_q + 1'b1;
          end else if (chunk_cnt_q != LAST_CHUNK) begin
            // Reload straight from the frame so chunk boundaries cost no cycle.
            shift_d     = codeword(next_idx);
            bit_cnt_d   = '0;
            chunk_cnt_d = next_chunk;
          end else begin
            shift_d     = '0;
            bit_cnt_d   = '0;
            chunk_cnt_d = '0;
            done_d      = 1'b1;
            state_d     = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy           = (state_q == EMIT);
  assign data_valid_out = (state_q == EMIT);
  assign data_out       = shift_q[CHUNK_SIZE-1];
  assign done           = done_q;

endmodule

// File: tb/tb_dict_value_decompressor.sv
// tb/tb_dict_value_decompressor.sv - randomized self-checking bench for dict_value_decompressor
// Expected streams come from a codebook table and a nearest-codeword compressor model.
module tb_dict_value_decompressor;

  localparam int NCH     = 32;
  localparam int IB      = 3;
  localparam int FRAME_W = NCH * IB;
  localparam int NBITS   = NCH * 4;

  logic               clk;
  logic               rst_n;
  logic [FRAME_W-1:0] compressed_in;
  logic               start;
  logic               busy;
  logic               data_out;
  logic               data_valid_out;
  logic               data_ready;
  logic               done;

  int n_vec;
  int n_err;

  logic [3:0] cb [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b1110, 4'b1111, 4'b1000, 4'b1100, 4'b0111};

  bit exp_bits[$];
  bit rx_bits[$];
  int rx_done_cycle;
  int rx_last_accept;
  int rx_gaps;
  int rx_unstable;
  bit rx_timeout;
  logic rx_busy_at_done;
  logic rx_valid_at_done;

  int ready_mode;
  int mid_start_cycle;
  bit chain_start;
  logic [FRAME_W-1:0] chain_frame;

  dict_value_decompressor #(
    .CHUNK_SIZE(4),
    .CODEBOOK_SIZE(8),
    .NUM_CHUNKS(NCH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .compressed_in(compressed_in),
    .start(start),
    .busy(busy),
    .data_out(data_out),
    .data_valid_out(data_valid_out),
    .data_ready(data_ready),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [FRAME_W-1:0] rand_frame();
    return {$urandom, $urandom, $urandom};
  endfunction

  // Reference decode: each index becomes its codeword, bit3 first, chunk 0 first.
  task automatic build_expected(input logic [FRAME_W-1:0] f);
    exp_bits.delete();
    for (int c = 0; c < NCH; c++) begin
      logic [2:0] idx;
      logic [3:0] cw;
      idx = f[c*IB +: IB];
      cw  = cb[idx];
      for (int b = 3; b >= 0; b--) exp_bits.push_back(cw[b]);
    end
  endtask

  function automatic logic [2:0] compress_chunk(input logic [3:0] x);
    int best;
    logic [2:0] bi;
    best = 99;
    bi   = 3'd0;
    for (int k = 0; k < 8; k++) begin
      int d;
      d = $countones(x ^ cb[k]);
      if (d < best) begin
        best = d;
        bi   = k[2:0];
      end
    end
    return bi;
  endfunction

  task automatic pulse_start(input logic [FRAME_W-1:0] f);
    compressed_in = f;
    start         = 1'b1;
    @(negedge clk);
    start         = 1'b0;
    compressed_in = rand_frame();
  endtask

  // Drives data_ready and records the accepted stream; called at the first negedge after a start edge.
  task automatic collect();
    bit held;
    bit held_val;
    bit rdy;
    rx_bits.delete();
    rx_gaps        = 0;
    rx_unstable    = 0;
    rx_timeout     = 1'b0;
    rx_done_cycle  = -1;
    rx_last_accept = -1;
    held           = 1'b0;
    held_val       = 1'b0;
    for (int c = 1; c <= 2000; c++) begin
      if (done === 1'b1) begin
        rx_done_cycle    = c;
        rx_busy_at_done  = busy;
        rx_valid_at_done = data_valid_out;
        if (chain_start) pulse_start(chain_frame);
        return;
      end
      start = (c == mid_start_cycle);
      if (c == mid_start_cycle) compressed_in = rand_frame();
      if (data_valid_out !== 1'b1) rx_gaps++;
      else if (held && data_out !== held_val) rx_unstable++;
      rdy = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      data_ready = rdy;
      if (data_valid_out === 1'b1 && rdy) begin
        rx_bits.push_back(data_out);
        rx_last_accept = c;
        held = 1'b0;
      end else if (data_valid_out === 1'b1) begin
        held     = 1'b1;
        held_val = data_out;
      end
      @(negedge clk);
    end
    rx_timeout = 1'b1;
  endtask

  task automatic test_reset();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_vec++; if (data_valid_out !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", data_valid_out); end
    n_vec++; if (data_out !== 1'b0) begin n_err++; $display("FAIL reset_data got=%b exp=0", data_out); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
  endtask

  task automatic test_all_zero();
    ready_mode = 0; mid_start_cycle = -1; chain_start = 1'b0;
    build_expected('0);
    pulse_start('0);
    collect();
    n_vec++; if (rx_timeout) begin n_err++; $display("FAIL zero_timeout got=timeout exp=done"); end
    n_vec++; if (rx_bits.size() != NBITS) begin n_err++; $display("FAIL zero_count got=%0d exp=%0d", rx_bits.size(), NBITS); end
    for (int i = 0; i < rx_bits.size() && i < NBITS; i++) begin
      n_vec++; if (rx_bits[i] !== exp_bits[i]) begin n_err++; $display("FAIL zero_bit[%0d] got=%b exp=%b", i, rx_bits[i], exp_bits[i]); end
    end
    n_vec++; if (rx_done_cycle != NBITS + 1) begin n_err++; $display("FAIL zero_done_cycle got=%0d exp=%0d", rx_done_cycle, NBITS + 1); end
    n_vec++; if (rx_busy_at_done !== 1'b0) begin n_err++; $display("FAIL zero_busy_at_done got=%b exp=0", rx_busy_at_done); end
    n_vec++; if (rx_valid_at_done !== 1'b0) begin n_err++; $display("FAIL zero_valid_at_done got=%b exp=0", rx_valid_at_done); end
    @(negedge clk);
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL zero_done_width got=%b exp=0", done); end
  endtask

  task automatic test_codebook_sweep();
    logic [FRAME_W-1:0] f;
    ready_mode = 0; mid_start_cycle = -1; chain_start = 1'b0;
    for (int c = 0; c < NCH; c++) f[c*IB +: IB] = 3'(c % 8);
    build_expected(f);
    pulse_start(f);
    collect();
    n_vec++; if (rx_bits.size() != NBITS) begin n_err++; $display("FAIL sweep_count got=%0d exp=%0d", rx_bits.size(), NBITS); end
    for (int i = 0; i < rx_bits.size() && i < NBITS; i++) begin
      n_vec++; if (rx_bits[i] !== exp_bits[i]) begin n_err++; $display("FAIL sweep_bit[%0d] got=%b exp=%b", i, rx_bits[i], exp_bits[i]); end
    end
    n_vec++; if (rx_gaps != 0) begin n_err++; $display("FAIL sweep_bubbles got=%0d exp=0", rx_gaps); end
    n_vec++; if (rx_done_cycle != NBITS + 1) begin n_err++; $display("FAIL sweep_done_cycle got=%0d exp=%0d", rx_done_cycle, NBITS + 1); end
  endtask

  task automatic test_backpressure();
    logic [FRAME_W-1:0] f;
    ready_mode = 1; mid_start_cycle = -1; chain_start = 1'b0;
    f = rand_frame();
    build_expected(f);
    pulse_start(f);
    collect();
    n_vec++; if (rx_timeout) begin n_err++; $display("FAIL bp_timeout got=timeout exp=done"); end
    n_vec++; if (rx_bits.size() != NBITS) begin n_err++; $display("FAIL bp_count got=%0d exp=%0d", rx_bits.size(), NBITS); end
    for (int i = 0; i < rx_bits.size() && i < NBITS; i++) begin
      n_vec++; if (rx_bits[i] !== exp_bits[i]) begin n_err++; $display("FAIL bp_bit[%0d] got=%b exp=%b", i, rx_bits[i], exp_bits[i]); end
    end
    n_vec++; if (rx_unstable != 0) begin n_err++; $display("FAIL bp_hold got=%0d exp=0", rx_unstable); end
    n_vec++; if (rx_gaps != 0) begin n_err++; $display("FAIL bp_valid_drop got=%0d exp=0", rx_gaps); end
    n_vec++; if (rx_done_cycle != rx_last_accept + 1) begin n_err++; $display("FAIL bp_done_cycle got=%0d exp=%0d", rx_done_cycle, rx_last_accept + 1); end
    data_ready = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [FRAME_W-1:0] fa;
    logic [FRAME_W-1:0] fb;
    fa = rand_frame();
    fb = rand_frame();
    ready_mode = 0; mid_start_cycle = 50; chain_start = 1'b1; chain_frame = fb;
    build_expected(fa);
    pulse_start(fa);
    collect();
    n_vec++; if (rx_bits.size() != NBITS) begin n_err++; $display("FAIL b2b_a_count got=%0d exp=%0d", rx_bits.size(), NBITS); end
    for (int i = 0; i < rx_bits.size() && i < NBITS; i++) begin
      n_vec++; if (rx_bits[i] !== exp_bits[i]) begin n_err++; $display("FAIL b2b_a_bit[%0d] got=%b exp=%b", i, rx_bits[i], exp_bits[i]); end
    end
    n_vec++; if (rx_done_cycle != NBITS + 1) begin n_err++; $display("FAIL b2b_a_done_cycle got=%0d exp=%0d", rx_done_cycle, NBITS + 1); end
    mid_start_cycle = -1; chain_start = 1'b0;
    build_expected(fb);
    collect();
    n_vec++; if (rx_bits.size() != NBITS) begin n_err++; $display("FAIL b2b_b_count got=%0d exp=%0d", rx_bits.size(), NBITS); end
    for (int i = 0; i < rx_bits.size() && i < NBITS; i++) begin
      n_vec++; if (rx_bits[i] !== exp_bits[i]) begin n_err++; $display("FAIL b2b_b_bit[%0d] got=%b exp=%b", i, rx_bits[i], exp_bits[i]); end
    end
    n_vec++; if (rx_gaps != 0) begin n_err++; $display("FAIL b2b_b_latency got=%0d exp=0", rx_gaps); end
    n_vec++; if (rx_done_cycle != NBITS + 1) begin n_err++; $display("FAIL b2b_b_done_cycle got=%0d exp=%0d", rx_done_cycle, NBITS + 1); end
  endtask

  task automatic test_round_trip();
    logic [3:0]         raw [NCH];
    logic [FRAME_W-1:0] f1;
    logic [2:0]         idx2;
    ready_mode = 1; mid_start_cycle = -1; chain_start = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      raw[c] = 4'($urandom_range(0, 15));
      f1[c*IB +: IB] = compress_chunk(raw[c]);
    end
    pulse_start(f1);
    collect();
    n_vec++; if (rx_bits.size() != NBITS) begin n_err++; $display("FAIL rt_count got=%0d exp=%0d", rx_bits.size(), NBITS); end
    for (int c = 0; c < NCH && (c * 4 + 3) < rx_bits.size(); c++) begin
      idx2 = compress_chunk({rx_bits[c*4], rx_bits[c*4+1], rx_bits[c*4+2], rx_bits[c*4+3]});
      n_vec++; if (idx2 !== f1[c*IB +: IB]) begin n_err++; $display("FAIL rt_chunk[%0d] got=%0d exp=%0d", c, idx2, f1[c*IB +: IB]); end
    end
    data_ready = 1'b1;
  endtask

  task automatic test_reset_mid_frame();
    logic [FRAME_W-1:0] f;
    bit saw_done;
    f = rand_frame();
    data_ready = 1'b1;
    pulse_start(f);
    repeat (40) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    n_vec++; if (data_valid_out !== 1'b0) begin n_err++; $display("FAIL rst_mid_valid got=%b exp=0", data_valid_out); end
    n_vec++; if (data_out !== 1'b0) begin n_err++; $display("FAIL rst_mid_data got=%b exp=0", data_out); end
    saw_done = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done !== 1'b0) saw_done = 1'b1;
    end
    rst_n = 1'b1;
    @(negedge clk);
    if (done !== 1'b0) saw_done = 1'b1;
    n_vec++; if (saw_done) begin n_err++; $display("FAIL rst_mid_no_done got=1 exp=0"); end
    ready_mode = 0; mid_start_cycle = -1; chain_start = 1'b0;
    f = rand_frame();
    build_expected(f);
    pulse_start(f);
    n_vec++; if (data_valid_out !== 1'b1) begin n_err++; $display("FAIL rst_restart_valid got=%b exp=1", data_valid_out); end
    collect();
    n_vec++; if (rx_bits.size() != NBITS) begin n_err++; $display("FAIL rst_restart_count got=%0d exp=%0d", rx_bits.size(), NBITS); end
    for (int i = 0; i < rx_bits.size() && i < NBITS; i++) begin
      n_vec++; if (rx_bits[i] !== exp_bits[i]) begin n_err++; $display("FAIL rst_restart_bit[%0d] got=%b exp=%b", i, rx_bits[i], exp_bits[i]); end
    end
  endtask

  initial begin
    n_vec         = 0;
    n_err         = 0;
    rst_n         = 1'b0;
    start         = 1'b0;
    data_ready    = 1'b0;
    compressed_in = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_all_zero();
    test_codebook_sweep();
    test_backpressure();
    test_back_to_back();
    @(negedge clk);
    test_round_trip();
    @(negedge clk);
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
